// File: rtl/sa_accept.sv
// Metropolis accept/reject stage with optional decision counters (SA_ACCEPT_STATS_EN).
// Latency: downhill result 1 cycle after req_valid, uphill result 2 cycles after prob capture.
// No backpressure: req_valid is dropped while busy, prob_valid is only honoured when awaited.
module sa_accept #(
  parameter logic [31:0] LFSR_SEED = 32'hACE12468
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_downhill,
  input  logic [31:0] prob,
  input  logic        prob_valid,
  output logic        busy,
  output logic        result_valid,
  output logic        accept,
  output logic [7:0]  debug
`ifdef SA_ACCEPT_STATS_EN
  ,
  output logic [15:0] accept_count,
  output logic [15:0] reject_count
`endif
);

  localparam logic [31:0] SEED = (LFSR_SEED == 32'h0) ? 32'h00000001 : LFSR_SEED;
  localparam logic [31:0] POLY = 32'h80200003;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_PROB = 2'd1,
    CONVERT   = 2'd2,
    DECIDE    = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CLS_NORMAL = 2'd0,
    CLS_ACCEPT = 2'd1,
    CLS_REJECT = 2'd2
  } cls_t;

  state_t      state_q;
  cls_t        cls_q, cls_d;
  logic [31:0] prob_q;
  logic [31:0] f_q, f_d;
  logic [31:0] lfsr_q, lfsr_d;
  logic        dh_vld_q;
  logic        acc_q;
  logic        dec;
  logic [7:0]  exp_w;
  logic [7:0]  shamt;

  assign exp_w = prob_q[30:23];
  // shamt is k-1 = 126-e; only meaningful for the NORMAL range 1..126
  assign shamt = 8'd126 - exp_w;

  always_comb begin
    cls_d = CLS_NORMAL;
    f_d   = 32'h0;
    if (prob_q[31] || (exp_w == 8'h00) || ((exp_w == 8'hFF) && (prob_q[22:0] != 23'h0))) begin
      cls_d = CLS_REJECT;
    end else if (exp_w >= 8'd127) begin
      cls_d = CLS_ACCEPT;
    end else if (shamt < 8'd32) begin
      f_d = {1'b1, prob_q[22:0], 8'h00} >> shamt[4:0];
    end
  end

  always_comb begin
    case (cls_q)
      CLS_ACCEPT: dec = 1'b1;
      CLS_REJECT: dec = 1'b0;
      default:    dec = (lfsr_q < f_q);
    endcase
  end

  assign lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? POLY : 32'h0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cls_q    <= CLS_NORMAL;
      prob_q   <= 32'h0;
      f_q      <= 32'h0;
      lfsr_q   <= SEED;
      dh_vld_q <= 1'b0;
      acc_q    <= 1'b0;
    end else begin
      dh_vld_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            if (req_downhill) begin
              dh_vld_q <= 1'b1;
              acc_q    <= 1'b1;
            end else if (prob_valid) begin
              prob_q  <= prob;
              state_q <= CONVERT;
            end else begin
              state_q <= WAIT_PROB;
            end
          end
        end
        WAIT_PROB: begin
          if (prob_valid) begin
            prob_q  <= prob;
            state_q <= CONVERT;
          end
        end
        CONVERT: begin
          f_q     <= f_d;
          cls_q   <= cls_d;
          state_q <= DECIDE;
        end
        DECIDE: begin
          // decision is visible this cycle; hold it and consume one random step
          acc_q   <= dec;
          lfsr_q  <= lfsr_d;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy         = (state_q != IDLE);
  assign result_valid = dh_vld_q | (state_q == DECIDE);
  assign accept       = (state_q == DECIDE) ? dec : acc_q;
  assign debug        = {state_q, cls_q, lfsr_q[3:0]};

`ifdef SA_ACCEPT_STATS_EN
  logic [15:0] acc_cnt_q;
  logic [15:0] rej_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_cnt_q <= 16'h0;
      rej_cnt_q <= 16'h0;
    end else if (result_valid) begin
      if (accept) begin
        if (acc_cnt_q != 16'hFFFF) acc_cnt_q <= acc_cnt_q + 16'd1;
      end else begin
        if (rej_cnt_q != 16'hFFFF) rej_cnt_q <= rej_cnt_q + 16'd1;
      end
    end
  end

  assign accept_count = acc_cnt_q;
  assign reject_count = rej_cnt_q;
`endif

endmodule

// File: tb/tb_sa_accept.sv
// Randomized bench for sa_accept against a float-level reference of the accept rule.
module tb_sa_accept;

  localparam logic [31:0] SEED = 32'h80000000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_downhill;
  logic [31:0] prob;
  logic        prob_valid;
  logic        busy;
  logic        result_valid;
  logic        accept;
  logic [7:0]  debug;
`ifdef SA_ACCEPT_STATS_EN
  logic [15:0] accept_count;
  logic [15:0] reject_count;
`endif

  always #5 clk = ~clk;

  sa_accept #(.LFSR_SEED(SEED)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_downhill (req_downhill),
    .prob         (prob),
    .prob_valid   (prob_valid),
    .busy         (busy),
    .result_valid (result_valid),
    .accept       (accept),
    .debug        (debug)
`ifdef SA_ACCEPT_STATS_EN
    ,
    .accept_count (accept_count),
    .reject_count (reject_count)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] m_lfsr;
  int          m_acc;
  int          m_rej;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] lfsr_next(input logic [31:0] l);
    return (l >> 1) ^ (l[0] ? 32'h80200003 : 32'h0);
  endfunction

  // 0 = ordinary probability, 1 = certain accept, 2 = reject (negative, zero/denormal, NaN)
  function automatic int cls_of(input logic [31:0] p);
    if (p[31] || (p[30:23] == 8'h00) || ((p[30:23] == 8'hFF) && (p[22:0] != 23'h0))) return 2;
    if (p[30:23] >= 8'd127) return 1;
    return 0;
  endfunction

  // floor(prob * 2^32) for 0 < prob < 1: (2^23+m) * 2^(e-150) * 2^32
  function automatic logic [31:0] thresh(input logic [31:0] p);
    logic [63:0] v;
    int          sh;
    v  = (64'd8388608 + {41'd0, p[22:0]}) << 40;
    sh = 158 - int'(p[30:23]);
    v  = v >> sh;
    return v[31:0];
  endfunction

  function automatic logic exp_accept(input logic [31:0] p, input logic [31:0] l);
    int c;
    c = cls_of(p);
    if (c == 1) return 1'b1;
    if (c == 2) return 1'b0;
    return (l < thresh(p));
  endfunction

  task automatic quiet();
    req_valid    = 1'b0;
    req_downhill = 1'b0;
    prob_valid   = 1'($urandom_range(0, 1));
    prob         = $urandom;
  endtask

  task automatic chk_stats();
`ifdef SA_ACCEPT_STATS_EN
    check_eq("accept_count", 32'(accept_count), 32'(m_acc));
    check_eq("reject_count", 32'(reject_count), 32'(m_rej));
`endif
  endtask

  task automatic do_down();
    req_valid    = 1'b1;
    req_downhill = 1'b1;
    prob_valid   = 1'($urandom_range(0, 1));
    prob         = $urandom;
    @(negedge clk);
    check_eq("dh_valid", 32'(result_valid), 32'd1);
    check_eq("dh_accept", 32'(accept), 32'd1);
    check_eq("dh_busy", 32'(busy), 32'd0);
    check_eq("dh_lfsr", 32'(debug[3:0]), 32'(m_lfsr[3:0]));
    m_acc++;
    quiet();
  endtask

  // gap = cycles spent in WAIT_PROB before prob arrives (0 = same cycle as req)
  task automatic do_up(input logic [31:0] p, input int gap);
    logic ea;
    req_valid    = 1'b1;
    req_downhill = 1'b0;
    prob_valid   = (gap == 0);
    prob         = (gap == 0) ? p : $urandom;
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      check_eq("wait_busy", 32'(busy), 32'd1);
      check_eq("wait_valid", 32'(result_valid), 32'd0);
      req_valid    = 1'($urandom_range(0, 1));
      req_downhill = 1'($urandom_range(0, 1));
      prob_valid   = (i == gap - 1);
      prob         = (i == gap - 1) ? p : $urandom;
    end
    @(negedge clk);
    check_eq("conv_valid", 32'(result_valid), 32'd0);
    check_eq("conv_busy", 32'(busy), 32'd1);
    req_valid    = 1'($urandom_range(0, 1));
    req_downhill = 1'($urandom_range(0, 1));
    prob_valid   = 1'($urandom_range(0, 1));
    prob         = $urandom;
    @(negedge clk);
    ea = exp_accept(p, m_lfsr);
    check_eq("up_valid", 32'(result_valid), 32'd1);
    check_eq("up_accept", 32'(accept), 32'(ea));
    check_eq("up_class", 32'(debug[5:4]), 32'(cls_of(p)));
    check_eq("up_lfsr", 32'(debug[3:0]), 32'(m_lfsr[3:0]));
    m_lfsr = lfsr_next(m_lfsr);
    if (ea) m_acc++;
    else m_rej++;
    quiet();
    @(negedge clk);
    check_eq("post_valid", 32'(result_valid), 32'd0);
    check_eq("post_busy", 32'(busy), 32'd0);
    check_eq("post_hold", 32'(accept), 32'(ea));
  endtask

  // stage: 0 = abort in WAIT_PROB, 1 = in CONVERT, 2 = in DECIDE
  task automatic do_abort(input int stage);
    req_valid    = 1'b1;
    req_downhill = 1'b0;
    prob_valid   = (stage != 0);
    prob         = $urandom;
    @(negedge clk);
    req_valid  = 1'b0;
    prob_valid = 1'b0;
    if (stage == 2) @(negedge clk);
    check_eq("ab_busy_pre", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    check_eq("ab_busy", 32'(busy), 32'd0);
    check_eq("ab_valid", 32'(result_valid), 32'd0);
    check_eq("ab_accept", 32'(accept), 32'd0);
    check_eq("ab_lfsr", 32'(debug[3:0]), 32'(SEED[3:0]));
    m_lfsr = SEED;
    m_acc  = 0;
    m_rej  = 0;
    @(negedge clk);
    rst = 1'b1;
    quiet();
    @(negedge clk);
    check_eq("ab_post_valid", 32'(result_valid), 32'd0);
    check_eq("ab_post_busy", 32'(busy), 32'd0);
    chk_stats();
  endtask

  function automatic logic [31:0] pick_prob();
    logic [31:0] edge_p [8];
    logic [7:0]  e;
    edge_p = '{32'h7F800000, 32'h7F800001, 32'h2F800000, 32'h2F000000,
               32'h3F7FFFFF, 32'h00400000, 32'h80000000, 32'h3F800000};
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: return edge_p[$urandom_range(0, 7)];
      default: begin
        e = 8'($urandom_range(100, 126));
        return {1'b0, e, 23'($urandom)};
      end
    endcase
  endfunction

  initial begin
    rst          = 1'b0;
    req_valid    = 1'b0;
    req_downhill = 1'b0;
    prob_valid   = 1'b0;
    prob         = 32'h0;
    m_lfsr       = SEED;
    m_acc        = 0;
    m_rej        = 0;
    repeat (2) @(negedge clk);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_valid", 32'(result_valid), 32'd0);
    check_eq("rst_accept", 32'(accept), 32'd0);
    check_eq("rst_lfsr", 32'(debug[3:0]), 32'(SEED[3:0]));
    chk_stats();
    rst = 1'b1;
    quiet();
    @(negedge clk);

    // first uphill decision uses the seed: 0x80000000 < 0xC0000000
    do_up(32'h3F400000, 0);
    do_down();
    do_abort(0);
    // back at the seed: 0x80000000 < 0x40000000 is false
    do_up(32'h3E800000, 1);
    do_down();
    do_up(32'h3F800000, 2);
    do_up(32'h00000000, 0);
    do_up(32'h7F800000, 1);
    @(negedge clk);
    chk_stats();
    do_up(32'hBF000000, 0);
    do_up(32'h7FC00000, 3);
    do_abort(1);
    do_abort(2);

    for (int t = 0; t < 300; t++) begin
      case ($urandom_range(0, 19))
        0:       do_abort(int'($urandom_range(0, 2)));
        1, 2, 3: do_down();
        default: do_up(pick_prob(), int'($urandom_range(0, 3)));
      endcase
    end
    @(negedge clk);
    chk_stats();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sa_accept.md
SA_ACCEPT -- requirements
Module: sa_accept

Interface
REQ-001 Parameter LFSR_SEED, default 32'hACE12468, is the initial 32-bit random state; a value of 0 SHALL be replaced by 32'h00000001.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 req_valid  in  1  one-cycle request for an accept/reject decision on one candidate move.
REQ-005 req_downhill  in  1  qualifies req_valid: 1 means the candidate energy delta is <= 0.
REQ-006 prob  in  32  IEEE-754 single value exp(-dE/T) from the negexp stage.
REQ-007 prob_valid  in  1  prob is valid this cycle.
REQ-008 busy  out  1  high whenever the FSM is not in IDLE.
REQ-009 result_valid  out  1  one-cycle pulse when the decision is available.
REQ-010 accept  out  1  decision, meaningful only while result_valid=1, held until the next decision.
REQ-011 debug  out  8  {state[1:0], prob_class[1:0], lfsr[3:0]}.

Function
REQ-012 The FSM SHALL have the states IDLE, WAIT_PROB, CONVERT and DECIDE.
REQ-013 IDLE with req_valid=1 and req_downhill=1 SHALL stay in IDLE and drive result_valid=1 and accept=1 on the next cycle, and the LFSR SHALL NOT advance.
REQ-014 IDLE with req_valid=1, req_downhill=0 and prob_valid=0 SHALL go to WAIT_PROB.
REQ-015 IDLE with req_valid=1, req_downhill=0 and prob_valid=1 in the same cycle SHALL capture prob and go directly to CONVERT.
REQ-016 WAIT_PROB with prob_valid=1 SHALL capture prob and go to CONVERT; with prob_valid=0 it SHALL stay in WAIT_PROB indefinitely.
REQ-017 prob_valid SHALL be ignored in IDLE without req_valid, and in CONVERT and DECIDE.
REQ-018 req_valid SHALL be ignored while busy=1, with no queueing.
REQ-019 CONVERT SHALL register a Q0.32 threshold F from the captured prob (s = sign, e = exponent, m = mantissa).
REQ-020 If s=1, or e=0, or e=255 with m!=0 (NaN), the class SHALL be REJECT.
REQ-021 If s=0 and e>=127 (prob >= 1.0, including +Inf), the class SHALL be ACCEPT.
REQ-022 Otherwise the class SHALL be NORMAL, with k = 127-e and F = {1'b1, m, 8'b0} >> (k-1); F SHALL be 0 when k-1 >= 32.
REQ-023 prob_class encoding: 0 = NORMAL, 1 = ACCEPT, 2 = REJECT.
REQ-024 DECIDE SHALL set accept as follows: 1 for ACCEPT, 0 for REJECT, and (lfsr < F, unsigned) for NORMAL.
REQ-025 DECIDE SHALL pulse result_valid, advance the LFSR one step and return to IDLE.
REQ-026 The LFSR SHALL be a 32-bit Galois LFSR with polynomial x^32+x^22+x^2+x+1, shifting right: next = (lfsr>>1) ^ (lfsr[0] ? 32'h80200003 : 0).
REQ-027 The LFSR SHALL advance only in DECIDE, so the first uphill decision after reset uses LFSR_SEED.
REQ-028 Uphill latency: result_valid SHALL be asserted exactly 2 cycles after the cycle in which prob is captured.
REQ-029 Downhill latency SHALL be 1 cycle after req_valid.

Reset
REQ-030 While rst=0, state=IDLE, busy=0, result_valid=0, accept=0, lfsr=LFSR_SEED (with the zero rule applied), captured prob=0 and F=0.
REQ-031 Reset asserted mid-operation (WAIT_PROB, CONVERT or DECIDE) SHALL abort the decision with no result_valid pulse.

Configuration
REQ-032 With SA_ACCEPT_STATS_EN defined, ports accept_count out 16 and reject_count out 16 SHALL exist.
REQ-033 Each count SHALL increment on every result_valid with the matching accept value, saturate at 16'hFFFF, and clear on reset.
REQ-034 Without SA_ACCEPT_STATS_EN, those ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-035 Downhill: req_valid=1, req_downhill=1 -> result_valid=1 and accept=1 one cycle later, lfsr unchanged.
REQ-036 LFSR_SEED=32'h80000000, uphill req, then prob=32'h3F400000 (0.75, F=32'hC0000000) -> accept=1 two cycles after capture, lfsr becomes 32'h40000000.
REQ-037 LFSR_SEED=32'h80000000, prob=32'h3E800000 (0.25, F=32'h40000000) -> accept=0.
REQ-038 Classification: prob=32'h3F800000 -> accept=1; prob=32'h00000000, 32'hBF000000 or 32'h7FC00000 -> accept=0; each reports the expected prob_class on debug.
REQ-039 Uphill req with simultaneous prob_valid -> result_valid 2 cycles later; a second req_valid while busy produces no extra result.
REQ-040 rst=0 while in WAIT_PROB -> IDLE, busy=0, no result_valid; with SA_ACCEPT_STATS_EN defined, counts are checked after 3 accepts and 2 rejects (3 and 2).
